// File: rtl/uart_bus_bridge.sv
`timescale 1ns/1ps
// uart_bus_bridge
//   Debug bus initiator. Decodes command frames arriving from the UART
//   receive path and issues single-word bus accesses. Reply bytes go back
//   to the UART transmit path.
//     write: 0x57 A3 A2 A1 A0 D3 D2 D1 D0 -> bus write, reply 0x4B
//     read : 0x52 A3 A2 A1 A0             -> bus read,  reply D3 D2 D1 D0
//     other first byte                    -> reply 0x3F, no bus access
//   A partial frame is dropped if no byte arrives for TIMEOUT_CYCLES clocks.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   rx_valid, rx_data   received byte strobe (no backpressure)
//   tx_valid, tx_ready, tx_data   reply byte handshake
//   m_wr, m_waddr, m_wdata, m_wstrb   single-cycle bus write
//   m_rd, m_raddr, m_rdata            single-cycle bus read, data next cycle
//   busy                high whenever a frame or reply is in progress
//   overrun             sticky: a byte arrived while it could not be taken
module uart_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        m_wr,
  output logic [31:0] m_waddr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_rd,
  output logic [31:0] m_raddr,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WR,
    RD,
    RDWAIT,
    RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  state_t          state;
  state_t          state_nxt;
  logic            is_wr;
  logic [1:0]      byte_cnt;
  logic [31:0]     addr_q;
  logic [31:0]     data_q;
  logic [31:0]     reply_q;
  logic [1:0]      resp_left;
  logic [TO_W-1:0] to_cnt;
  logic            overrun_q;
  logic            in_frame;
  logic            timeout_hit;
  logic            is_cmd;
  logic            drop_byte;

  assign in_frame    = (state == ADDR) || (state == DATA);
  // Fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES;
  // a byte arriving in that cycle still counts as in time.
  assign timeout_hit = in_frame && !rx_valid &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign is_cmd      = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
  assign drop_byte   = rx_valid && !in_frame && (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          state_nxt = is_cmd ? ADDR : RESP;
        end
      end
      ADDR: begin
        if (timeout_hit) begin
          state_nxt = IDLE;
        end else if (rx_valid && (byte_cnt == 2'd3)) begin
          state_nxt = is_wr ? DATA : RD;
        end
      end
      DATA: begin
        if (timeout_hit) begin
          state_nxt = IDLE;
        end else if (rx_valid && (byte_cnt == 2'd3)) begin
          state_nxt = WR;
        end
      end
      WR:     state_nxt = RESP;
      RD:     state_nxt = RDWAIT;
      RDWAIT: state_nxt = RESP;
      RESP: begin
        if (tx_ready && (resp_left == 2'd0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      is_wr     <= 1'b0;
      byte_cnt  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      reply_q   <= '0;
      resp_left <= '0;
      to_cnt    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_valid || timeout_hit || !in_frame) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (drop_byte) begin
        overrun_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_valid) begin
            is_wr    <= (rx_data == CMD_WRITE);
            byte_cnt <= '0;
            if (!is_cmd) begin
              reply_q   <= {RSP_ERR, 24'h0};
              resp_left <= 2'd0;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr_q   <= {addr_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            data_q   <= {data_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WR: begin
          reply_q   <= {RSP_ACK, 24'h0};
          resp_left <= 2'd0;
        end
        RDWAIT: begin
          reply_q   <= m_rdata;
          resp_left <= 2'd3;
        end
        RESP: begin
          // Reply is sent MSB first by shifting the next byte into the top.
          if (tx_ready) begin
            reply_q <= {reply_q[23:0], 8'h00};
            if (resp_left != 2'd0) begin
              resp_left <= resp_left - 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign tx_valid = (state == RESP);
  assign tx_data  = tx_valid ? reply_q[31:24] : '0;
  assign m_wr     = (state == WR);
  assign m_rd     = (state == RD);
  assign m_wstrb  = m_wr ? 4'hF : 4'h0;
  assign m_waddr  = addr_q & 32'hFFFF_FFFC;
  assign m_raddr  = addr_q & 32'hFFFF_FFFC;
  assign m_wdata  = data_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
`timescale 1ns/1ps
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        m_wr;
  logic [31:0] m_waddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_rd;
  logic [31:0] m_raddr;
  logic [31:0] m_rdata = 32'h0;
  logic        busy;
  logic        overrun;

  uart_bus_bridge #(
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .m_wr(m_wr), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rd(m_rd), .m_raddr(m_raddr), .m_rdata(m_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  logic [31:0] slave_val = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave: returns slave_val the cycle after a read strobe, zero otherwise.
  always @(posedge clk) m_rdata <= m_rd ? slave_val : 32'h0;

  always @(negedge clk) begin
    if (rstn) begin
      if (m_wr) wr_cnt++;
      if (m_rd) rd_cnt++;
      if (m_wr || m_rd) chk("strobe_exclusive", {31'h0, m_wr & m_rd}, 32'h0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    send_byte(cmd);
    if (cmd == 8'h57 || cmd == 8'h52) begin
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
      if (cmd == 8'h57) begin
        for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
      end
    end
  endtask

  // Collects n reply bytes, holding tx_ready low for 'hold' cycles per byte.
  task automatic get_reply(input int unsigned n, input int unsigned hold, output logic [31:0] got);
    logic [7:0] b;
    got = 32'h0;
    for (int unsigned k = 0; k < n; k++) begin
      for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
      if (!tx_valid) begin
        checks++;
        errors++;
        $display("FAIL reply_wait: got tx_valid=0 expected 1 within 50 cycles (byte %0d)", k);
        return;
      end
      b = tx_data;
      for (int unsigned h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_valid", {31'h0, tx_valid}, 32'h1);
        chk("hold_data", {24'h0, tx_data}, {24'h0, b});
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      got = {got[23:0], b};
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slave;
    int unsigned n_reply;
    logic [31:0] exp_reply;
    int unsigned exp_wr;
    int unsigned exp_rd;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [31:0] got;
    logic [31:0] exp;
    int unsigned w0, r0;

    vecs[0] = '{8'h57, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0,         1, 32'h4B00_0000, 1, 0, 32'h0100_0010};
    vecs[1] = '{8'h52, 32'h0100_0010, 32'h0,         32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 0, 1, 32'h0100_0010};
    vecs[2] = '{8'h41, 32'h0,         32'h0,         32'h0,         1, 32'h3F00_0000, 0, 0, 32'h0};
    vecs[3] = '{8'h57, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,         1, 32'h4B00_0000, 1, 0, 32'hFFFF_FFFC};
    vecs[4] = '{8'h52, 32'h0000_0002, 32'h0,         32'hA5A5_5A5A, 4, 32'hA5A5_5A5A, 0, 1, 32'h0000_0000};
    vecs[5] = '{8'h77, 32'h0,         32'h0,         32'h0,         1, 32'h3F00_0000, 0, 0, 32'h0};
    vecs[6] = '{8'h52, 32'h8765_4321, 32'h0,         32'h0000_00FF, 4, 32'h0000_00FF, 0, 1, 32'h8765_4320};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_strobes", {30'h0, m_wr, m_rd}, 32'h0);
    chk("rst_wstrb", {28'h0, m_wstrb}, 32'h0);
    chk("rst_waddr", m_waddr, 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Table-driven frames
    foreach (vecs[i]) begin
      w0 = wr_cnt;
      r0 = rd_cnt;
      slave_val = vecs[i].slave;
      send_frame(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      chk("m_wr_latency", {31'h0, m_wr}, vecs[i].exp_wr);
      chk("m_rd_latency", {31'h0, m_rd}, vecs[i].exp_rd);
      if (vecs[i].exp_wr != 0) begin
        chk("waddr", m_waddr, vecs[i].exp_addr);
        chk("wdata", m_wdata, vecs[i].wdata);
        chk("wstrb", {28'h0, m_wstrb}, 32'hF);
      end
      if (vecs[i].exp_rd != 0) begin
        chk("raddr", m_raddr, vecs[i].exp_addr);
        @(negedge clk);
        chk("rdwait_tx_valid", {31'h0, tx_valid}, 32'h0);
        @(negedge clk);
        chk("read_tx_valid_rise", {31'h0, tx_valid}, 32'h1);
      end
      get_reply(vecs[i].n_reply, 0, got);
      exp = vecs[i].exp_reply >> (8 * (4 - vecs[i].n_reply));
      chk("reply", got, exp);
      @(negedge clk);
      chk("end_busy", {31'h0, busy}, 32'h0);
      chk("end_tx_valid", {31'h0, tx_valid}, 32'h0);
      chk("wr_count", wr_cnt - w0, vecs[i].exp_wr);
      chk("rd_count", rd_cnt - r0, vecs[i].exp_rd);
    end

    // tx_ready while idle is ignored; then a read with slow transmitter
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_busy", {31'h0, busy}, 32'h0);
    chk("idle_ready_tx_valid", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    slave_val = 32'hCAFE_F00D;
    send_frame(8'h52, 32'h0300_0007, 32'h0);
    chk("slow_raddr", m_raddr, 32'h0300_0004);
    get_reply(4, 5, got);
    chk("slow_reply", got, 32'hCAFE_F00D);
    @(negedge clk);
    chk("slow_end_busy", {31'h0, busy}, 32'h0);

    // Timeout mid-address drops the partial write
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (14) @(negedge clk);
    chk("timeout_still_busy", {31'h0, busy}, 32'h1);
    repeat (3) @(negedge clk);
    chk("timeout_idle", {31'h0, busy}, 32'h0);
    chk("timeout_no_reply", {31'h0, tx_valid}, 32'h0);
    slave_val = 32'h1122_3344;
    send_frame(8'h52, 32'h0000_0020, 32'h0);
    chk("post_timeout_raddr", m_raddr, 32'h0000_0020);
    get_reply(4, 0, got);
    chk("post_timeout_reply", got, 32'h1122_3344);
    chk("timeout_no_write", wr_cnt - w0, 32'h0);

    // Byte during reply: dropped, overrun set, reply intact
    @(negedge clk);
    chk("overrun_clear", {31'h0, overrun}, 32'h0);
    slave_val = 32'h0A0B_0C0D;
    send_frame(8'h52, 32'h0000_0040, 32'h0);
    repeat (2) @(negedge clk);
    chk("ovr_tx_valid", {31'h0, tx_valid}, 32'h1);
    send_byte(8'h57);
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    chk("ovr_tx_data", {24'h0, tx_data}, 32'h0A);
    get_reply(4, 0, got);
    chk("ovr_reply", got, 32'h0A0B_0C0D);
    @(negedge clk);
    chk("ovr_end_busy", {31'h0, busy}, 32'h0);

    // Byte arriving in the same cycle the last reply byte is accepted
    slave_val = 32'h5566_7788;
    send_frame(8'h52, 32'h0000_0044, 32'h0);
    get_reply(3, 0, got);
    chk("last_byte_data", {24'h0, tx_data}, 32'h88);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk("last_byte_drop_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("last_byte_drop_tx", {31'h0, tx_valid}, 32'h0);
    chk("overrun_sticky", {31'h0, overrun}, 32'h1);

    // Asynchronous reset mid-DATA
    w0 = wr_cnt;
    send_byte(8'h57);
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
    chk("mid_data_busy", {31'h0, busy}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_strobes", {30'h0, m_wr, m_rd}, 32'h0);
    chk("async_rst_overrun", {31'h0, overrun}, 32'h0);
    chk("async_rst_waddr", m_waddr, 32'h0);
    chk("async_rst_wdata", m_wdata, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Asynchronous reset mid-reply
    slave_val = 32'h1357_9BDF;
    send_frame(8'h52, 32'h0000_0080, 32'h0);
    repeat (2) @(negedge clk);
    chk("pre_rst_tx_valid", {31'h0, tx_valid}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("async_rst_tx_data", {24'h0, tx_data}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Next frame after reset works
    send_frame(8'h57, 32'h0000_0102, 32'h0BAD_CAFE);
    chk("post_rst_wr", {31'h0, m_wr}, 32'h1);
    chk("post_rst_waddr", m_waddr, 32'h0000_0100);
    chk("post_rst_wdata", m_wdata, 32'h0BAD_CAFE);
    get_reply(1, 0, got);
    chk("post_rst_reply", got, 32'h0000_004B);
    chk("post_rst_wr_count", wr_cnt - w0, 32'h1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
